// File: rtl/clock_phase_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_phase_ctrl_pkg
// Description : Shared clocking package. Holds the command op codes, the
//               phase-controller state encoding and the datapath widths used
//               by the controller, its command interface and the clock
//               generator that sits beside it.
// Contents    : cmd_op_e      - command op codes (NOP/SETDIV/SHIFT/STRETCH)
//               ctrl_state_e  - controller state encoding
//               DIV_W, CMD_OP_W, CMD_ARG_W, CNT_W, TCNT_W - field widths
//               tcnt_last()   - last timeout count value for a given TIMEOUT
// Revision    : 1.0 - initial release
// ============================================================================
package clock_phase_ctrl_pkg;

  localparam int DIV_W     = 6;   // clock generator divider select width
  localparam int CMD_OP_W  = 2;   // command op code width
  localparam int CMD_ARG_W = 8;   // command argument width
  localparam int CNT_W     = 8;   // SHIFT/STRETCH cycle counter width
  localparam int TCNT_W    = 16;  // sync timeout counter width

  typedef enum logic [CMD_OP_W-1:0] {
    OP_NOP     = 2'd0,
    OP_SETDIV  = 2'd1,
    OP_SHIFT   = 2'd2,
    OP_STRETCH = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_STRETCH   = 3'd3,
    ST_DONE      = 3'd4
  } ctrl_state_e;

  // The timeout counter holds the number of WAIT_SYNC cycles already spent
  // without sync, so the final permitted cycle is the one where it reads
  // TIMEOUT-1.
  function automatic logic [TCNT_W-1:0] tcnt_last(input int unsigned timeout);
    return TCNT_W'(timeout - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_phase_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_phase_ctrl_if
// Description : Command handshake bundle between a requester and the clock
//               phase controller. A command transfers on a cycle where
//               cmd_valid and cmd_ready are both high; the requester holds
//               cmd_op/cmd_arg stable until then.
// Signals     : cmd_valid - command offered            (master -> slave)
//               cmd_ready - controller accepts this cycle (slave -> master)
//               cmd_op    - op code, see cmd_op_e       (master -> slave)
//               cmd_arg   - SETDIV divider / cycle count (master -> slave)
// Modports    : master - requester side, slave - controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_phase_ctrl_if;
  import clock_phase_ctrl_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CMD_OP_W-1:0]  cmd_op;
  logic [CMD_ARG_W-1:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );

endinterface
`default_nettype wire

// File: rtl/clock_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_phase_ctrl
// Description : Command-driven phase controller for an external clock
//               generator. Accepts one command at a time and either retunes
//               the divider on the generator's next sync pulse, holds the
//               generator phase for N cycles, or vetoes its state machine for
//               N cycles after the next sync. Waiting for sync is bounded by
//               TIMEOUT cycles; an expired wait raises a sticky error.
// Parameters  : TIMEOUT  - max cycles spent waiting for sync (1..65535)
//               DIV_INIT - clkdiv value after reset
// Ports       : clk      - system clock, rising edge
//               reset    - asynchronous active-high reset
//               cmd      - command handshake (slave modport)
//               sync     - one-cycle sync pulse from the clock generator
//               clkdiv   - registered divider select to the generator
//               shift    - registered phase-hold to the generator
//               stretch  - registered veto to the generator state machine
//               busy     - a command is in progress
//               done     - one-cycle pulse when a command completes/aborts
//               error    - sticky sync-timeout flag, cleared on next accept
// Revision    : 1.0 - initial release
// ============================================================================
module clock_phase_ctrl
  import clock_phase_ctrl_pkg::*;
#(
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DIV_W-1:0]  DIV_INIT = 6'd0
) (
  input  logic               clk,
  input  logic               reset,
  clock_phase_ctrl_if.slave  cmd,
  input  logic               sync,
  output logic [DIV_W-1:0]   clkdiv,
  output logic               shift,
  output logic               stretch,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam logic [TCNT_W-1:0] c_tcnt_last = tcnt_last(TIMEOUT);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  ctrl_state_e         r_state;
  cmd_op_e             r_op;        // op latched at acceptance
  logic [DIV_W-1:0]    r_div_new;   // SETDIV target, applied only on sync
  logic [CNT_W-1:0]    r_cnt;       // remaining SHIFT/STRETCH cycles
  logic [TCNT_W-1:0]   r_tcnt;      // WAIT_SYNC cycles already elapsed
  logic [DIV_W-1:0]    r_clkdiv;
  logic                r_shift;
  logic                r_stretch;
  logic                r_done;
  logic                r_error;

  // --------------------------------------------------------------------------
  // Next-state values
  // --------------------------------------------------------------------------
  ctrl_state_e         w_state_nxt;
  cmd_op_e             w_op_nxt;
  logic [DIV_W-1:0]    w_div_new_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [TCNT_W-1:0]   w_tcnt_nxt;
  logic [DIV_W-1:0]    w_clkdiv_nxt;
  logic                w_error_nxt;
  cmd_op_e             w_cmd_op;
  logic                w_arg_zero;

  assign w_cmd_op   = cmd_op_e'(cmd.cmd_op);
  assign w_arg_zero = (cmd.cmd_arg == '0);

  // --------------------------------------------------------------------------
  // State register. The generator-facing strobes are registered copies of
  // the next state, so they switch on the same edge as the state itself and
  // can never overlap (SHIFT and STRETCH are exclusive states).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_NOP;
      r_div_new <= '0;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_clkdiv  <= DIV_INIT;
      r_shift   <= 1'b0;
      r_stretch <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_div_new <= w_div_new_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_clkdiv  <= w_clkdiv_nxt;
      r_shift   <= (w_state_nxt == ST_SHIFT);
      r_stretch <= (w_state_nxt == ST_STRETCH);
      r_done    <= (w_state_nxt == ST_DONE);
      r_error   <= w_error_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_div_new_nxt = r_div_new;
    w_cnt_nxt     = r_cnt;
    w_tcnt_nxt    = r_tcnt;
    w_clkdiv_nxt  = r_clkdiv;
    w_error_nxt   = r_error;

    unique case (r_state)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          w_op_nxt      = w_cmd_op;
          w_div_new_nxt = cmd.cmd_arg[DIV_W-1:0];
          w_tcnt_nxt    = '0;
          w_cnt_nxt     = '0;
          w_error_nxt   = 1'b0;
          unique case (w_cmd_op)
            OP_NOP: begin
              w_state_nxt = ST_DONE;
            end
            OP_SETDIV: begin
              w_state_nxt = ST_WAIT_SYNC;
            end
            OP_SHIFT: begin
              // A zero count completes without ever touching the generator.
              w_cnt_nxt   = cmd.cmd_arg;
              w_state_nxt = w_arg_zero ? ST_DONE : ST_SHIFT;
            end
            OP_STRETCH: begin
              // A zero count skips the sync wait as well.
              w_cnt_nxt   = cmd.cmd_arg;
              w_state_nxt = w_arg_zero ? ST_DONE : ST_WAIT_SYNC;
            end
            default: begin
              w_state_nxt = ST_DONE;
            end
          endcase
        end
      end

      ST_WAIT_SYNC: begin
        // Sync takes priority over the timeout, so a sync landing on the
        // very last permitted cycle still counts as a successful wait.
        if (sync) begin
          w_tcnt_nxt = '0;
          if (r_op == OP_STRETCH) begin
            w_state_nxt = ST_STRETCH;
          end else begin
            w_clkdiv_nxt = r_div_new;
            w_state_nxt  = ST_DONE;
          end
        end else if (r_tcnt == c_tcnt_last) begin
          w_tcnt_nxt  = '0;
          w_error_nxt = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_tcnt_nxt = r_tcnt + 16'd1;
        end
      end

      ST_SHIFT, ST_STRETCH: begin
        // r_cnt counts the strobe cycles still to be spent, including this
        // one; leaving on 1 gives exactly N high cycles.
        if (r_cnt <= 8'd1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cmd.cmd_ready = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign clkdiv        = r_clkdiv;
  assign shift         = r_shift;
  assign stretch       = r_stretch;
  assign done          = r_done;
  assign error         = r_error;

endmodule
`default_nettype wire

// File: doc/clock_phase_ctrl.md
CLOCK_PHASE_CTRL -- requirements
Module: clock_phase_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max clk cycles waited for sync before abort (1..65535).
REQ-002 SHALL have parameter DIV_INIT, default 6'd0: clkdiv value after reset.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  controller accepts command this cycle.
REQ-007 cmd_op  input  2  0=NOP, 1=SETDIV, 2=SHIFT, 3=STRETCH.
REQ-008 cmd_arg  input  8  SETDIV: [5:0] new clkdiv; SHIFT/STRETCH: cycle count.
REQ-009 sync  input  1  sync pulse from clock generator (1 clk wide).
REQ-010 clkdiv  output  6  divider select to clock generator, registered.
REQ-011 shift  output  1  phase-hold to clock generator; counter frozen while high.
REQ-012 stretch  output  1  veto to clock generator state machine.
REQ-013 busy  output  1  command in progress (state != IDLE).
REQ-014 done  output  1  one-cycle pulse when a command completes or aborts.
REQ-015 error  output  1  sticky; set on sync timeout, cleared by next accepted command.

Function
REQ-016 States SHALL be IDLE, WAIT_SYNC, SHIFT, STRETCH, DONE.
REQ-017 cmd_ready SHALL equal (state==IDLE); a command SHALL be accepted when cmd_valid && cmd_ready, with op/arg latched that cycle.
REQ-018 NOP SHALL go IDLE->DONE; done pulses the cycle after acceptance.
REQ-019 SETDIV SHALL go IDLE->WAIT_SYNC; on the first cycle sync==1, clkdiv SHALL load arg[5:0] next edge, then DONE.
REQ-020 SHIFT with arg=N>0 SHALL assert shift for exactly N consecutive cycles starting the cycle after acceptance, then DONE; N=0 SHALL go directly to DONE without asserting shift.
REQ-021 STRETCH with arg=N>0 SHALL go WAIT_SYNC; the cycle after sync is seen, stretch SHALL assert for exactly N cycles, then DONE; N=0 SHALL go to DONE without asserting stretch or waiting for sync.
REQ-022 WAIT_SYNC SHALL count cycles from entry; if TIMEOUT cycles elapse without sync, SHALL set error, leave clkdiv unchanged, assert neither shift nor stretch, go DONE.
REQ-023 sync arriving in the same cycle as the timeout count reaches TIMEOUT SHALL be treated as sync (no error).
REQ-024 DONE SHALL last one cycle with done=1, then IDLE; a new command SHALL be acceptable the cycle after DONE.
REQ-025 Cycle counter SHALL be 8 bit for SHIFT/STRETCH (max 255), timeout counter 16 bit; no wrap-around.
REQ-026 shift and stretch SHALL be registered outputs, never high simultaneously.
REQ-027 cmd_valid while busy SHALL be ignored (not accepted, no side effects); requester holds until ready.

Reset
REQ-028 On reset: state=IDLE, clkdiv=DIV_INIT, shift=0, stretch=0, done=0, error=0, busy=0, counters=0.
REQ-029 Reset mid-command SHALL abort immediately with no done pulse; a pending SETDIV SHALL not be applied.

Structure
REQ-030 Op codes (NOP/SETDIV/SHIFT/STRETCH) and state encoding SHALL live in the shared clocking package.
REQ-031 Single flat module; no sub-modules; clock generator instantiated beside it, not inside.

Verification
REQ-032 SHIFT arg=5 -> shift high exactly 5 cycles starting 1 cycle after acceptance; done 1 cycle after shift falls.
REQ-033 SETDIV arg=6'h09, sync pulse 7 cycles later -> clkdiv changes 6'h00->6'h09 on edge after sync; done next cycle; error=0.
REQ-034 STRETCH arg=3, TIMEOUT=20, no sync -> after 20 cycles error=1, done pulse, stretch never high; next NOP clears error.
REQ-035 STRETCH arg=3 with sync on the 20th WAIT_SYNC cycle (TIMEOUT=20) -> stretch high 3 cycles, error=0.
REQ-036 SHIFT arg=0 and STRETCH arg=0 -> done 1 cycle after acceptance, shift/stretch stay 0.
REQ-037 Reset asserted during SHIFT arg=100 at cycle 10 -> shift drops asynchronously, no done, clkdiv=DIV_INIT, cmd_ready=1 after release.
